huffman_decoder: RTL

//  Downstream stage of the Huffman encoder; it rebuilds the original character stream.
//  - Buffers the serial encoded bitstream, then captures the codeword table and the
//    per-character code lengths.
//  - Decodes each character by table match and emits it over a ready/valid byte interface.

---
 rtl/huff_pkg.sv | 33 +++
 rtl/huff_bit_buffer.sv | 66 ++++++
 rtl/huffman_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// Shared Huffman codec definitions: widths, decoder state encoding, error codes and
// the codeword table entry layout used by both the encoder and the decoder.
package huff_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int MAX_CHAR  = 255;
  localparam int MAX_SYM   = 255;
  localparam int LEN_W     = 4;
  localparam int MAX_BITS  = MAX_CHAR * BIT_WIDTH;
  localparam int PTR_W     = $clog2(MAX_BITS + 1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NO_MATCH = 2'd1;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd2;
  localparam logic [1:0] ERR_BITS     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_BITS = 3'd1,
    ST_RX_CW   = 3'd2,
    ST_RX_LN   = 3'd3,
    ST_FETCH   = 3'd4,
    ST_SEARCH  = 3'd5,
    ST_EMIT    = 3'd6,
    ST_DONE    = 3'd7
  } dec_state_e;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] cw;
    logic [BIT_WIDTH-1:0] sym;
  } cw_entry_t;

endpackage

// File: rtl/huff_bit_buffer.sv
// Encoded-bit store with a write pointer and a BIT_WIDTH-wide MSB-aligned read window
// starting at rp_i; window bits at positions >= len_i read as zero.
module huff_bit_buffer
  import huff_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic                 bit_i,
  input  logic [PTR_W-1:0]     rp_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic [PTR_W-1:0]     wp_o,
  output logic                 ovf_o,
  output logic [BIT_WIDTH-1:0] win_o
);

  localparam int IDX_W = PTR_W + 1;

  logic [MAX_BITS-1:0] mem_q;
  logic [PTR_W-1:0]    wp_q;
  logic [PTR_W-1:0]    wp_d;
  logic                full_s;
  logic [IDX_W-1:0]    idx_s;

  assign full_s = (wp_q == PTR_W'(MAX_BITS));
  assign ovf_o  = wr_en_i && full_s;
  assign wp_o   = wp_q;

  always_comb begin
    wp_d = wp_q;
    if (clr_i) begin
      wp_d = '0;
    end else if (wr_en_i && !full_s) begin
      wp_d = wp_q + PTR_W'(1);
    end else begin
      wp_d = wp_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
    end else begin
      wp_q <= wp_d;
    end
  end

  // Storage is never cleared: only bits below the write pointer are ever consumed.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !full_s && !clr_i) begin
      mem_q[wp_q] <= bit_i;
    end
  end

  always_comb begin
    win_o = '0;
    idx_s = '0;
    for (int b = 0; b < BIT_WIDTH; b++) begin
      idx_s = IDX_W'(rp_i) + IDX_W'(b);
      win_o[BIT_WIDTH-1-b] = ((LEN_W'(b) < len_i) && (idx_s < IDX_W'(MAX_BITS)))
                             ? mem_q[idx_s[PTR_W-1:0]] : 1'b0;
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder: buffers the bitstream, captures table and lengths, decodes by linear search.
// Define HUFF_DEC_BITCHECK_EN to flag a frame whose bit count differs from the summed lengths.
module huffman_decoder
  import huff_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   hdr_valid_i,
  input  logic [BIT_WIDTH-1:0]   num_n_i,
  input  logic [BIT_WIDTH-1:0]   num_N_i,
  input  logic                   bit_valid_i,
  input  logic                   bit_i,
  input  logic                   bits_done_i,
  input  logic                   cw_valid_i,
  input  logic [2*BIT_WIDTH-1:0] data_cw_i,
  input  logic                   ln_valid_i,
  input  logic [LEN_W-1:0]       data_ln_i,
  output logic                   char_valid_o,
  input  logic                   char_ready_i,
  output logic [BIT_WIDTH-1:0]   char_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o
);

  localparam int SUM_W = PTR_W + 1;

  dec_state_e           state_q, state_d;
  logic [BIT_WIDTH-1:0] n_q, n_d, nchar_q, nchar_d, c_q, c_d, l_q, l_d;
  logic [BIT_WIDTH-1:0] j_q, j_d, k_q, k_d, key_q, key_d, char_q, char_d;
  logic [PTR_W-1:0]     rp_q, rp_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 char_valid_q, char_valid_d, done_q, done_d, err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;

  cw_entry_t            tbl_q [MAX_SYM];
  logic [LEN_W-1:0]     len_mem_q [MAX_CHAR];

  logic                 buf_clr_s, buf_we_s, ovf_s, bad_len_s;
  logic [PTR_W-1:0]     wp_s;
  logic [BIT_WIDTH-1:0] win_s;
  logic [LEN_W-1:0]     cur_len_s;
  logic [SUM_W-1:0]     need_s;
  cw_entry_t            cur_ent_s;
`ifdef HUFF_DEC_BITCHECK_EN
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [PTR_W-1:0]     wp_nxt_s;
  logic                 bit_mis_s;
`endif

  assign buf_we_s  = (state_q == ST_RX_BITS) && bit_valid_i;
  assign cur_len_s = len_mem_q[j_q];
  assign cur_ent_s = tbl_q[k_q];
  assign need_s    = SUM_W'(rp_q) + SUM_W'(cur_len_s);
  assign bad_len_s = (cur_len_s > LEN_W'(BIT_WIDTH)) ||
                     ((cur_len_s == '0) && (n_q != BIT_WIDTH'(1))) ||
                     (need_s > SUM_W'(wp_s));
`ifdef HUFF_DEC_BITCHECK_EN
  assign wp_nxt_s  = wp_s + PTR_W'(buf_we_s && !ovf_s);
`endif

  huff_bit_buffer u_bit_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (buf_clr_s),
    .wr_en_i (buf_we_s),
    .bit_i   (bit_i),
    .rp_i    (rp_q),
    .len_i   (cur_len_s),
    .wp_o    (wp_s),
    .ovf_o   (ovf_s),
    .win_o   (win_s)
  );

  // Table and length memories only load during their own receive phase.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == ST_RX_CW) && cw_valid_i) begin
      tbl_q[c_q] <= cw_entry_t'(data_cw_i);
    end
    if (!rst_i && (state_q == ST_RX_LN) && ln_valid_i) begin
      len_mem_q[l_q] <= data_ln_i;
    end
  end

  always_comb begin
    state_d = state_q;  n_d = n_q;  nchar_d = nchar_q;  c_d = c_q;  l_d = l_q;
    j_d = j_q;  k_d = k_q;  rp_d = rp_q;  len_d = len_q;  key_d = key_q;  char_d = char_q;
    char_valid_d = char_valid_q;  done_d = done_q;  err_d = err_q;  err_code_d = err_code_q;
    buf_clr_s = 1'b0;
`ifdef HUFF_DEC_BITCHECK_EN
    sum_d = sum_q;
    bit_mis_s = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (hdr_valid_i) begin
          n_d = num_n_i;  nchar_d = num_N_i;
          c_d = '0;  l_d = '0;  j_d = '0;  k_d = '0;  rp_d = '0;
          done_d = 1'b0;  err_d = 1'b0;  err_code_d = ERR_NONE;  buf_clr_s = 1'b1;
`ifdef HUFF_DEC_BITCHECK_EN
          sum_d = '0;
`endif
          state_d = ST_RX_BITS;
        end else begin
          state_d = state_q;
        end
      end
      ST_RX_BITS: begin
        if (ovf_s) begin
          err_d = 1'b1;
          err_code_d = err_q ? err_code_q : ERR_BITS;
        end else begin
          err_d = err_q;
        end
        if (bits_done_i) begin
          state_d = ((n_q == '0) || (nchar_q == '0)) ? ST_DONE : ST_RX_CW;
        end else begin
          state_d = state_q;
        end
      end
      ST_RX_CW: begin
        if (cw_valid_i) begin
          c_d = c_q + BIT_WIDTH'(1);
          state_d = (c_q == n_q - BIT_WIDTH'(1)) ? ST_RX_LN : ST_RX_CW;
        end else begin
          c_d = c_q;
        end
      end
      ST_RX_LN: begin
        if (ln_valid_i) begin
          l_d = l_q + BIT_WIDTH'(1);
`ifdef HUFF_DEC_BITCHECK_EN
          sum_d = sum_q + SUM_W'(data_ln_i);
`endif
          state_d = (l_q == nchar_q - BIT_WIDTH'(1)) ? ST_FETCH : ST_RX_LN;
        end else begin
          l_d = l_q;
        end
      end
      ST_FETCH: begin
        len_d = cur_len_s;  key_d = win_s;  k_d = '0;
        if (bad_len_s) begin
          err_d = 1'b1;
          err_code_d = err_q ? err_code_q : ERR_BAD_LEN;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        // A zero-length code is only legal for a single-symbol table and always hits entry 0.
        if ((len_q == '0) || (cur_ent_s.cw == key_q)) begin
          char_d = cur_ent_s.sym;  char_valid_d = 1'b1;  state_d = ST_EMIT;
        end else if (k_q == n_q - BIT_WIDTH'(1)) begin
          err_d = 1'b1;
          err_code_d = err_q ? err_code_q : ERR_NO_MATCH;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + BIT_WIDTH'(1);
        end
      end
      ST_EMIT: begin
        if (char_ready_i) begin
          char_valid_d = 1'b0;
          rp_d = rp_q + PTR_W'(len_q);
          j_d = j_q + BIT_WIDTH'(1);
          state_d = (j_q + BIT_WIDTH'(1) == nchar_q) ? ST_DONE : ST_FETCH;
        end else begin
          char_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef HUFF_DEC_BITCHECK_EN
    bit_mis_s  = (state_d == ST_DONE) && (state_q != ST_DONE) && !err_d &&
                 (SUM_W'(wp_nxt_s) != sum_q);
    err_d      = err_d || bit_mis_s;
    err_code_d = bit_mis_s ? ERR_BITS : err_code_d;
`endif
    done_d = done_d || ((state_d == ST_DONE) && (state_q != ST_DONE));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;  n_q <= '0;  nchar_q <= '0;  c_q <= '0;  l_q <= '0;
      j_q <= '0;  k_q <= '0;  rp_q <= '0;  len_q <= '0;  key_q <= '0;  char_q <= '0;
      char_valid_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;  err_code_q <= ERR_NONE;
`ifdef HUFF_DEC_BITCHECK_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;  n_q <= n_d;  nchar_q <= nchar_d;  c_q <= c_d;  l_q <= l_d;
      j_q <= j_d;  k_q <= k_d;  rp_q <= rp_d;  len_q <= len_d;  key_q <= key_d;  char_q <= char_d;
      char_valid_q <= char_valid_d;  done_q <= done_d;  err_q <= err_d;  err_code_q <= err_code_d;
`ifdef HUFF_DEC_BITCHECK_EN
      sum_q <= sum_d;
`endif
    end
  end

  assign char_valid_o = char_valid_q;
  assign char_o       = char_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
